inst_fetch_queue: RTL and testbench

//  Parametrised instruction-fetch unit for the cs147sec05 processor: owns the program counter and

---
 rtl/inst_fetch_queue.sv | 126 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: owns the fetch PC, prefetches sequential words into a small
// {pc, instruction} queue, and flushes/restarts on branch, jump and jump-register redirects.
module inst_fetch_queue #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 26,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 'h0001000
) (
  input  logic                    CLK,
  input  logic                    RST,
  output logic                    MEM_REQ,
  output logic [ADDR_WIDTH-1:0]   MEM_ADDR,
  input  logic                    MEM_ACK,
  input  logic [DATA_WIDTH-1:0]   MEM_DATA,
  output logic                    INST_VALID,
  output logic [DATA_WIDTH-1:0]   INST,
  output logic [ADDR_WIDTH-1:0]   INST_PC,
  input  logic                    INST_READY,
  input  logic                    REDIR,
  input  logic [1:0]              REDIR_MODE,
  input  logic [15:0]             REDIR_IMM,
  input  logic [25:0]             REDIR_ADDR,
  input  logic [DATA_WIDTH-1:0]   REDIR_REG,
  output logic [$clog2(DEPTH):0]  COUNT
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] One = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] fpc_q, fpc_d, addr_q, addr_d, last_pc_q, last_pc_d;
  logic [ADDR_WIDTH-1:0] base, br_off, target;
  logic                  req_q, req_d, squash_q, squash_d;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] inst_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q [DEPTH];
  logic                  ack, pop, push, hold;

  assign ack  = req_q & MEM_ACK;
  assign hold = req_q & ~MEM_ACK;
  assign pop  = (count_q != '0) & INST_READY;
  // Squashed data and data arriving with a redirect are dropped.
  assign push = ack & ~squash_q & ~REDIR;

  assign MEM_REQ    = req_q;
  assign MEM_ADDR   = addr_q;
  assign INST_VALID = (count_q != '0);
  assign INST       = inst_mem_q[rd_ptr_q];
  assign INST_PC    = pc_mem_q[rd_ptr_q];
  assign COUNT      = count_q;

  assign base   = pop ? INST_PC : last_pc_q;
  assign br_off = {{(ADDR_WIDTH-16){REDIR_IMM[15]}}, REDIR_IMM};

  always_comb begin
    target = ADDR_WIDTH'(REDIR_ADDR);
    case (REDIR_MODE)
      2'b00:   target = base + One + br_off;
      2'b10:   target = ADDR_WIDTH'(REDIR_REG);
      default: target = ADDR_WIDTH'(REDIR_ADDR);
    endcase
  end

  always_comb begin
    count_d   = REDIR ? '0 : count_q + CntW'(push) - CntW'(pop);
    last_pc_d = pop ? INST_PC : last_pc_q;

    fpc_d = fpc_q;
    if (REDIR) begin
      fpc_d = target;
    end else if (ack && !squash_q) begin
      fpc_d = fpc_q + One;
    end

    squash_d = squash_q;
    if (REDIR && hold) begin
      squash_d = 1'b1;
    end else if (ack) begin
      squash_d = 1'b0;
    end

    // A pending request is never withdrawn; otherwise issue whenever a slot is free.
    req_d  = hold | (count_d < DepthC);
    addr_d = (!hold && req_d) ? fpc_d : addr_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fpc_q     <= START_ADDR;
      addr_q    <= '0;
      last_pc_q <= START_ADDR - One;
      req_q     <= 1'b0;
      squash_q  <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      fpc_q     <= fpc_d;
      addr_q    <= addr_d;
      last_pc_q <= last_pc_d;
      req_q     <= req_d;
      squash_q  <= squash_d;
      count_q   <= count_d;
      if (REDIR) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          inst_mem_q[wr_ptr_q] <= MEM_DATA;
          pc_mem_q[wr_ptr_q]   <= fpc_q;
          wr_ptr_q             <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Table-driven bench for inst_fetch_queue with a scoreboard of expected {pc, instruction} pops.
module tb_inst_fetch_queue;

  localparam int DW    = 32;
  localparam int AW    = 26;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          MEM_REQ, MEM_ACK, INST_VALID, INST_READY, REDIR;
  logic [AW-1:0] MEM_ADDR, INST_PC;
  logic [DW-1:0] MEM_DATA, INST, REDIR_REG;
  logic [1:0]    REDIR_MODE;
  logic [15:0]   REDIR_IMM;
  logic [25:0]   REDIR_ADDR;
  logic [2:0]    COUNT;

  inst_fetch_queue #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH),
    .START_ADDR(26'h0001000)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .MEM_REQ   (MEM_REQ),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_ACK   (MEM_ACK),
    .MEM_DATA  (MEM_DATA),
    .INST_VALID(INST_VALID),
    .INST      (INST),
    .INST_PC   (INST_PC),
    .INST_READY(INST_READY),
    .REDIR     (REDIR),
    .REDIR_MODE(REDIR_MODE),
    .REDIR_IMM (REDIR_IMM),
    .REDIR_ADDR(REDIR_ADDR),
    .REDIR_REG (REDIR_REG),
    .COUNT     (COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ready, ack_en, redir;
    logic [1:0]  mode;
    logic [15:0] imm;
    logic [25:0] raddr;
    logic [31:0] rreg;
    logic [2:0]  cnt;
    logic        vld, req;
    logic [25:0] addr;
  } vec_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } ent_t;

  int   n_vec = 0;
  int   n_err = 0;
  ent_t sb[$];
  bit   squash_m = 1'b0;
  vec_t tab_a[$];
  vec_t tab_b[$];

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {6'b101101, a};
  endfunction

  function automatic vec_t p(input logic rdy, input logic ack, input int cnt, input logic vld,
                             input logic rq, input logic [25:0] ad);
    vec_t v;
    v.ready = rdy; v.ack_en = ack; v.redir = 1'b0; v.mode = 2'b00; v.imm = '0;
    v.raddr = '0; v.rreg = '0; v.cnt = 3'(cnt); v.vld = vld; v.req = rq; v.addr = ad;
    return v;
  endfunction

  function automatic vec_t r(input logic rdy, input logic ack, input logic [1:0] md,
                             input logic [15:0] imm, input logic [25:0] ra,
                             input logic [31:0] rr, input int cnt, input logic vld,
                             input logic rq, input logic [25:0] ad);
    vec_t v;
    v = p(rdy, ack, cnt, vld, rq, ad);
    v.redir = 1'b1; v.mode = md; v.imm = imm; v.raddr = ra; v.rreg = rr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Entered at posedge+1: drives one cycle of inputs, scores pops/acks, checks post-edge state.
  task automatic step(input vec_t v, input string tag, input int idx);
    ent_t e;
    INST_READY = v.ready;
    REDIR      = v.redir;
    REDIR_MODE = v.mode;
    REDIR_IMM  = v.imm;
    REDIR_ADDR = v.raddr;
    REDIR_REG  = v.rreg;
    MEM_ACK    = v.ack_en & MEM_REQ;
    MEM_DATA   = word_of(MEM_ADDR);
    if (INST_VALID && INST_READY) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL %s[%0d] pop: got pc %0h, expected no valid entry", tag, idx, INST_PC);
      end else begin
        e = sb.pop_front();
        check($sformatf("%s[%0d] inst_pc", tag, idx), 64'(INST_PC), 64'(e.pc));
        check($sformatf("%s[%0d] inst", tag, idx), 64'(INST), 64'(e.data));
      end
    end
    if (REDIR) sb.delete();
    if (MEM_ACK) begin
      if (!squash_m && !REDIR) begin
        e.pc   = MEM_ADDR;
        e.data = word_of(MEM_ADDR);
        sb.push_back(e);
      end
      squash_m = 1'b0;
    end else if (REDIR && MEM_REQ) begin
      squash_m = 1'b1;
    end
    @(posedge CLK);
    #1;
    check($sformatf("%s[%0d] count", tag, idx), 64'(COUNT), 64'(v.cnt));
    check($sformatf("%s[%0d] valid", tag, idx), 64'(INST_VALID), 64'(v.vld));
    check($sformatf("%s[%0d] mem_req", tag, idx), 64'(MEM_REQ), 64'(v.req));
    if (v.req) check($sformatf("%s[%0d] mem_addr", tag, idx), 64'(MEM_ADDR), 64'(v.addr));
  endtask

  task automatic release_reset();
    MEM_ACK = 1'b0; REDIR = 1'b0; INST_READY = 1'b0;
    sb.delete();
    squash_m = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst count", 64'(COUNT), 64'd0);
    check("rst valid", 64'(INST_VALID), 64'd0);
    check("rst mem_req", 64'(MEM_REQ), 64'd0);
    check("rst mem_addr", 64'(MEM_ADDR), 64'd0);
    check("rst inst", 64'(INST), 64'd0);
    check("rst inst_pc", 64'(INST_PC), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("post-rst mem_req", 64'(MEM_REQ), 64'd1);
    check("post-rst mem_addr", 64'(MEM_ADDR), 64'h1000);
    check("post-rst count", 64'(COUNT), 64'd0);
  endtask

  initial begin
    MEM_ACK = 1'b0; MEM_DATA = '0; INST_READY = 1'b0; REDIR = 1'b0;
    REDIR_MODE = 2'b00; REDIR_IMM = '0; REDIR_ADDR = '0; REDIR_REG = '0;

    // Streaming with single-cycle memory, then stall decode to build up a backlog.
    tab_a.push_back(p(1, 1, 1, 1, 1, 26'h1001));
    tab_a.push_back(p(1, 1, 1, 1, 1, 26'h1002));
    tab_a.push_back(p(1, 1, 1, 1, 1, 26'h1003));
    tab_a.push_back(p(1, 1, 1, 1, 1, 26'h1004));
    tab_a.push_back(p(0, 1, 2, 1, 1, 26'h1005));
    tab_a.push_back(p(0, 1, 3, 1, 1, 26'h1006));

    // Fill to full, single pop, redirects (branch/jump/jr/reserved), squash, wrap.
    tab_b.push_back(p(0, 1, 1, 1, 1, 26'h1001));
    tab_b.push_back(p(0, 1, 2, 1, 1, 26'h1002));
    tab_b.push_back(p(0, 1, 3, 1, 1, 26'h1003));
    tab_b.push_back(p(0, 1, 4, 1, 0, 26'h0));
    tab_b.push_back(p(0, 1, 4, 1, 0, 26'h0));
    tab_b.push_back(p(1, 0, 3, 1, 1, 26'h1004));
    tab_b.push_back(p(1, 0, 2, 1, 1, 26'h1004));
    tab_b.push_back(r(1, 1, 2'b00, 16'hFFFE, 26'h0, 32'h0, 0, 0, 1, 26'h1001));
    tab_b.push_back(p(0, 1, 1, 1, 1, 26'h1002));
    tab_b.push_back(r(0, 0, 2'b00, 16'h0005, 26'h0, 32'h0, 0, 0, 1, 26'h1002));
    tab_b.push_back(p(0, 1, 0, 0, 1, 26'h1008));
    tab_b.push_back(p(0, 1, 1, 1, 1, 26'h1009));
    tab_b.push_back(r(1, 0, 2'b01, 16'h0, 26'h1005, 32'h0, 0, 0, 1, 26'h1009));
    tab_b.push_back(p(1, 1, 0, 0, 1, 26'h1005));
    tab_b.push_back(p(1, 0, 0, 0, 1, 26'h1005));
    tab_b.push_back(r(1, 0, 2'b10, 16'h0, 26'h0, 32'h0002_0040, 0, 0, 1, 26'h1005));
    tab_b.push_back(p(1, 0, 0, 0, 1, 26'h1005));
    tab_b.push_back(p(1, 0, 0, 0, 1, 26'h1005));
    tab_b.push_back(p(1, 1, 0, 0, 1, 26'h20040));
    tab_b.push_back(p(1, 1, 1, 1, 1, 26'h20041));
    tab_b.push_back(p(1, 1, 1, 1, 1, 26'h20042));
    tab_b.push_back(r(0, 0, 2'b11, 16'h0, 26'h0000123, 32'h0, 0, 0, 1, 26'h20042));
    tab_b.push_back(r(0, 0, 2'b01, 16'h0, 26'h3FFFFFF, 32'h0, 0, 0, 1, 26'h20042));
    tab_b.push_back(p(0, 1, 0, 0, 1, 26'h3FFFFFF));
    tab_b.push_back(p(0, 1, 1, 1, 1, 26'h0000000));
    tab_b.push_back(p(1, 1, 1, 1, 1, 26'h0000001));
    tab_b.push_back(r(1, 0, 2'b00, 16'hFFFE, 26'h0, 32'h0, 0, 0, 1, 26'h0000001));
    tab_b.push_back(p(1, 1, 0, 0, 1, 26'h3FFFFFF));
    tab_b.push_back(p(1, 1, 1, 1, 1, 26'h0000000));
    tab_b.push_back(p(1, 1, 1, 1, 1, 26'h0000001));
    tab_b.push_back(r(0, 1, 2'b11, 16'h0, 26'h0002000, 32'h0, 0, 0, 1, 26'h2000));
    tab_b.push_back(p(1, 1, 1, 1, 1, 26'h2001));
    tab_b.push_back(p(1, 0, 0, 0, 1, 26'h2001));

    release_reset();
    foreach (tab_a[i]) step(tab_a[i], "stream", i);

    // Asynchronous reset mid-cycle with a backlog and a live request.
    #2;
    RST = 1'b1;
    #1;
    check("async-rst count", 64'(COUNT), 64'd0);
    check("async-rst mem_req", 64'(MEM_REQ), 64'd0);
    check("async-rst valid", 64'(INST_VALID), 64'd0);
    release_reset();

    foreach (tab_b[i]) step(tab_b[i], "main", i);
    check("final sb empty", 64'(sb.size()), 64'(COUNT));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
